uart_rx_frontend: RTL and testbench
===================================

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL have parameter OVS_DIV, default 27, meaning clk cycles per 16x-oversample tick (50 MHz / (115200*16)).
REQ-002 SHALL have parameter OVS_RATE, default 16, meaning oversample ticks per bit.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is rising-edge clocked.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port REC_DATA  output  8 (word_lenght_t)  last correctly received byte.
REQ-007 SHALL have port REC_DONE  output  1  one-cycle strobe marking REC_DATA valid; this is the MxV ENABLE input.
REQ-008 SHALL have port FRAME_ERR  output  1  one-cycle strobe when the stop bit is sampled low.
REQ-009 SHALL have port BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-010 SHALL pass RX through a 2-FF synchronizer (reset value 1) before any use.
REQ-011 SHALL generate an oversample tick, one clk wide, every OVS_DIV clks. The counter free-runs and restarts at 0 on detection of a start edge.
REQ-012 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH, plus PARITY when configured.
REQ-013 SHALL move IDLE->START on a synchronized RX falling edge.
REQ-014 SHALL resample RX in START at tick 8 (mid-bit). Low -> DATA. High -> IDLE as a false start, with no strobe.
REQ-015 SHALL sample 8 data bits, LSB first, every OVS_RATE ticks at mid-bit, using a 3-bit bit counter. After bit 7, go to STOP (or PARITY).
REQ-016 SHALL sample the stop bit at mid-bit. High -> pulse REC_DONE for exactly one clk, update REC_DATA in that same cycle, then IDLE.
REQ-017 SHALL, when the stop bit is sampled low, pulse FRAME_ERR for one clk, leave REC_DATA unchanged, not assert REC_DONE, and go to WAIT_HIGH.
REQ-018 SHALL stay in WAIT_HIGH until the synchronized RX is high, then go to IDLE. A held break therefore yields exactly one FRAME_ERR.
REQ-019 SHALL hold REC_DATA stable between REC_DONE strobes.
REQ-020 SHALL make REC_DONE and FRAME_ERR mutually exclusive.
REQ-021 SHALL assert REC_DONE within 2 clks of the mid-stop sample tick.
REQ-022 SHALL accept a new start edge in the clk immediately after returning to IDLE; back-to-back frames are supported with no idle gap.

Reset
REQ-023 SHALL, while rst=0, force REC_DATA=8'h00, REC_DONE=0, FRAME_ERR=0, BUSY=0, state=IDLE, all counters=0 and the synchronizer flops=1.
REQ-024 SHALL abort any frame on reset mid-frame with no strobe, and resume at IDLE waiting for a fresh falling edge after release.

Configuration
REQ-025 SHALL, with macro UART_RX_PARITY_EN defined, add port PARITY_ERR (output, 1) and a PARITY state that samples an even-parity bit between bit 7 and the stop bit.
REQ-026 SHALL, with UART_RX_PARITY_EN defined and a parity mismatch, pulse PARITY_ERR in the stop-sample cycle, suppress REC_DONE and leave REC_DATA unchanged. FRAME_ERR takes precedence if both errors occur.
REQ-027 SHALL, without UART_RX_PARITY_EN, have no PARITY_ERR port and no PARITY state; the frame is 8N1.

Structure
REQ-028 SHALL take word_lenght_t from Definitions_Package and add there the state enum type and the default constants for OVS_DIV and OVS_RATE.
REQ-029 SHALL place the oversample tick generator in sub-module uart_baud_tick (inputs clk, rst, restart; output tick).

Verification
REQ-030 SHALL cover: 8N1 frame 0xFE at 115200 -> REC_DONE high for exactly 1 clk, REC_DATA=8'hFE, FRAME_ERR=0.
REQ-031 SHALL cover: back-to-back frames FE,03,01,04,EF with no idle gap -> 5 REC_DONE strobes carrying those values in that order.
REQ-032 SHALL cover: a 4-tick low glitch on RX -> no strobe, BUSY returns to 0, and a following 0x03 frame is received correctly.
REQ-033 SHALL cover: frame 0x55 with stop bit low, then RX held low 3 bit-times -> one FRAME_ERR, REC_DATA keeps its prior value, and the next 0x02 frame is received.
REQ-034 SHALL cover: rst=0 asserted at data bit 4 of 0xAA -> outputs at reset values, no strobe; after release, frame 0x06 -> REC_DATA=8'h06.
REQ-035 SHALL cover, with UART_RX_PARITY_EN defined: 0x03 with parity bit 1 -> PARITY_ERR pulse and no REC_DONE; 0x03 with parity bit 0 -> REC_DONE and REC_DATA=8'h03.

Source files
------------

// File: rtl/uart_rx_frontend_pkg.sv
// -----------------------------------------------------------------------------
// Definitions_Package
// Purpose : shared types and constants for the UART receive front end.
//           - word_lenght_t : one received data byte
//           - rx_state_t    : receiver state encoding
//           - DEF_OVS_DIV / DEF_OVS_RATE : default oversample settings
//             (50 MHz clock, 115200 baud, 16x oversampling)
//           - even_parity() : parity helper used by the optional parity check
// Build option: define UART_RX_PARITY_EN to add the PARITY state.
// -----------------------------------------------------------------------------
package Definitions_Package;

    typedef logic [7:0] word_lenght_t;

    localparam int unsigned DEF_OVS_DIV  = 32'd27;
    localparam int unsigned DEF_OVS_RATE = 32'd16;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_PARITY    = 3'd5
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;
`endif

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input word_lenght_t data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_frontend_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Purpose : free-running divider producing a one-clk oversample tick every
//           OVS_DIV clocks. 'restart' zeroes the divider so that sampling
//           phase is aligned to a detected start edge.
// Ports   : clk     - system clock (rising edge)
//           rst     - asynchronous active-low reset
//           restart - synchronous divider restart
//           tick    - registered one-clk oversample strobe
// -----------------------------------------------------------------------------
module uart_baud_tick
    import Definitions_Package::*;
#(
    parameter int unsigned OVS_DIV = DEF_OVS_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   CW       = (OVS_DIV > 32'd1) ? $clog2(OVS_DIV) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS_DIV - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Divider next-state: wrap at OVS_DIV-1 and flag the tick on the wrap.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider and tick registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// uart_rx_frontend
// Purpose : 16x-oversampled UART receiver (8 data bits, LSB first, 1 stop).
//           Delivers each correctly framed byte on REC_DATA with a one-clk
//           REC_DONE strobe; a low stop bit gives a one-clk FRAME_ERR and the
//           receiver then waits for the line to return high.
// Ports   : clk        - system clock (rising edge)
//           rst        - asynchronous active-low reset
//           RX         - serial input, idle high, asynchronous
//           REC_DATA   - last correctly received byte
//           REC_DONE   - one-clk strobe, REC_DATA valid
//           FRAME_ERR  - one-clk strobe, stop bit sampled low
//           PARITY_ERR - one-clk strobe, even-parity mismatch (option only)
//           BUSY       - receiver not idle
// Build option: UART_RX_PARITY_EN adds an even-parity bit before the stop bit.
// -----------------------------------------------------------------------------
module uart_rx_frontend
    import Definitions_Package::*;
#(
    parameter int unsigned OVS_DIV  = DEF_OVS_DIV,
    parameter int unsigned OVS_RATE = DEF_OVS_RATE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RX,
    output word_lenght_t REC_DATA,
    output logic         REC_DONE,
    output logic         FRAME_ERR,
`ifdef UART_RX_PARITY_EN
    output logic         PARITY_ERR,
`endif
    output logic         BUSY
);

    localparam int unsigned   TW        = (OVS_RATE > 32'd1) ? $clog2(OVS_RATE) : 32'd1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVS_RATE / 32'd2 - 32'd1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS_RATE - 32'd1);

    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    logic          fall_s;
    logic          restart_s;
    logic          tick_s;

    rx_state_t     state_q,    state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q,  bit_cnt_d;
    word_lenght_t  shift_q,    shift_d;
    word_lenght_t  data_q,     data_d;
    logic          done_q,     done_d;
    logic          ferr_q,     ferr_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bit_q,  par_bit_d;
    logic          perr_q,     perr_d;
    logic          par_bad_s;
`endif

    uart_baud_tick #(
        .OVS_DIV (OVS_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall_s = rx_prev_q & ~rx_sync_q;

`ifdef UART_RX_PARITY_EN
    assign par_bad_s = (even_parity(shift_q) != par_bit_q);
`endif

    // Receiver next-state and strobe logic. Each bit is sampled when the
    // tick counter reaches its target; START waits half a bit, later bits a
    // whole bit, which places every sample at mid-bit.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        restart_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d    = ST_START;
                    restart_s  = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (tick_cnt_q == TICK_MID)) begin
                    tick_cnt_d = '0;
                    // A line that is high again at mid-start was only a glitch.
                    state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
                end else if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_DATA: begin
                if (tick_s && (tick_cnt_q == TICK_LAST)) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_s && (tick_cnt_q == TICK_LAST)) begin
                    tick_cnt_d = '0;
                    par_bit_d  = rx_sync_q;
                    state_d    = ST_STOP;
                end else if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s && (tick_cnt_q == TICK_LAST)) begin
                    tick_cnt_d = '0;
                    if (!rx_sync_q) begin
                        // Framing error wins over any parity error.
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_s) begin
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end else begin
                        done_d  = 1'b1;
                        data_d  = shift_q;
                        state_d = ST_IDLE;
                    end
                end else if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_WAIT_HIGH: begin
                // A held break must not look like a stream of new start bits.
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Receiver state, counters, data and strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign REC_DATA   = data_q;
    assign REC_DONE   = done_q;
    assign FRAME_ERR  = ferr_q;
    assign BUSY       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frontend
// Directed bench for uart_rx_frontend at default settings (27 clk per tick,
// 16 ticks per bit). A frame table drives normal and framing-error frames;
// hand sequences cover the glitch, held break, mid-frame reset and, when
// UART_RX_PARITY_EN is defined, parity mismatch.
// -----------------------------------------------------------------------------
module tb_uart_rx_frontend;

    localparam int BIT_CLKS = 27 * 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX  = 1'b1;
    logic [7:0] REC_DATA;
    logic       REC_DONE;
    logic       FRAME_ERR;
    logic       BUSY;
`ifdef UART_RX_PARITY_EN
    logic       PARITY_ERR;
`endif

    uart_rx_frontend dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .REC_DATA   (REC_DATA),
        .REC_DONE   (REC_DONE),
        .FRAME_ERR  (FRAME_ERR),
`ifdef UART_RX_PARITY_EN
        .PARITY_ERR (PARITY_ERR),
`endif
        .BUSY       (BUSY)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Strobe monitor, sampled on the falling edge.
    int         done_cnt     = 0;
    int         ferr_cnt     = 0;
    int         perr_cnt     = 0;
    int         wide_cnt     = 0;
    int         both_cnt     = 0;
    int         unstable_cnt = 0;
    logic       prev_done    = 1'b0;
    logic [7:0] held_data    = 8'h00;

    always @(negedge clk) begin
        if (REC_DONE === 1'b1) done_cnt++;
        if (FRAME_ERR === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (PARITY_ERR === 1'b1) perr_cnt++;
`endif
        if (REC_DONE === 1'b1 && prev_done === 1'b1) wide_cnt++;
        if (REC_DONE === 1'b1 && FRAME_ERR === 1'b1) both_cnt++;
        if (rst === 1'b0) held_data = 8'h00;
        else if (REC_DONE === 1'b1) held_data = REC_DATA;
        else if (REC_DATA !== held_data) unstable_cnt++;
        prev_done = REC_DONE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        RX = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
    endtask

    // Frame with correct even parity when the parity option is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap_bits;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];
    int   d0;
    int   f0;
    int   p0;

    initial begin
        vecs[0] = '{8'hFE, 1'b1, 1, 1, 0, 8'hFE};
        vecs[1] = '{8'hFE, 1'b1, 0, 1, 0, 8'hFE};
        vecs[2] = '{8'h03, 1'b1, 0, 1, 0, 8'h03};
        vecs[3] = '{8'h01, 1'b1, 0, 1, 0, 8'h01};
        vecs[4] = '{8'h04, 1'b1, 0, 1, 0, 8'h04};
        vecs[5] = '{8'hEF, 1'b1, 1, 1, 0, 8'hEF};
        vecs[6] = '{8'h81, 1'b0, 1, 0, 1, 8'hEF};
        vecs[7] = '{8'hA5, 1'b1, 1, 1, 0, 8'hA5};

        // Reset state.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_rec_data", 32'(REC_DATA), 32'h00);
        check("rst_rec_done", 32'(REC_DONE), 32'h0);
        check("rst_frame_err", 32'(FRAME_ERR), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
`ifdef UART_RX_PARITY_EN
        check("rst_parity_err", 32'(PARITY_ERR), 32'h0);
`endif
        rst = 1'b1;
        idle_bits(1);

        // Table of frames, including back-to-back and a low stop bit.
        for (int v = 0; v < 8; v++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop_bit);
            idle_bits(vecs[v].gap_bits);
            check($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_data", v), 32'(REC_DATA), 32'(vecs[v].exp_data));
        end

        // Four-tick glitch is rejected, then 0x03 is received.
        d0 = done_cnt;
        RX = 1'b0;
        repeat (4 * 27) @(posedge clk);
        idle_bits(1);
        @(negedge clk);
        check("glitch_busy", 32'(BUSY), 32'h0);
        check("glitch_no_done", 32'(done_cnt - d0), 32'h0);
        send_frame(8'h03, 1'b1);
        idle_bits(1);
        check("after_glitch_data", 32'(REC_DATA), 32'h03);
        check("after_glitch_done", 32'(done_cnt - d0), 32'h1);

        // 0x55 with low stop, break held three more bits, then 0x02.
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        RX = 1'b0;
        repeat (3 * BIT_CLKS) @(posedge clk);
        idle_bits(1);
        check("break_ferr", 32'(ferr_cnt - f0), 32'h1);
        check("break_no_done", 32'(done_cnt - d0), 32'h0);
        check("break_data_kept", 32'(REC_DATA), 32'h03);
        send_frame(8'h02, 1'b1);
        idle_bits(1);
        check("after_break_data", 32'(REC_DATA), 32'h02);

        // Reset during data bit 4 of 0xAA, then 0x06.
        d0 = done_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((i % 2) == 1) ? 1'b1 : 1'b0);
        RX = 1'b0;
        repeat (BIT_CLKS / 2) @(posedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_rec_data", 32'(REC_DATA), 32'h00);
        check("midrst_rec_done", 32'(REC_DONE), 32'h0);
        check("midrst_frame_err", 32'(FRAME_ERR), 32'h0);
        check("midrst_busy", 32'(BUSY), 32'h0);
        RX = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        idle_bits(1);
        check("midrst_no_done", 32'(done_cnt - d0), 32'h0);
        send_frame(8'h06, 1'b1);
        idle_bits(1);
        check("after_rst_data", 32'(REC_DATA), 32'h06);
        check("after_rst_done", 32'(done_cnt - d0), 32'h1);

`ifdef UART_RX_PARITY_EN
        // 0x03 has even parity 0: parity bit 1 is a mismatch.
        d0 = done_cnt;
        p0 = perr_cnt;
        send_frame_par(8'h03, 1'b1);
        idle_bits(1);
        check("par_bad_perr", 32'(perr_cnt - p0), 32'h1);
        check("par_bad_no_done", 32'(done_cnt - d0), 32'h0);
        check("par_bad_data_kept", 32'(REC_DATA), 32'h06);
        send_frame_par(8'h03, 1'b0);
        idle_bits(1);
        check("par_ok_done", 32'(done_cnt - d0), 32'h1);
        check("par_ok_data", 32'(REC_DATA), 32'h03);
        check("par_ok_no_perr", 32'(perr_cnt - p0), 32'h1);
`else
        p0 = perr_cnt;
        check("no_parity_strobes", 32'(p0), 32'h0);
`endif

        // Whole-run strobe properties.
        check("done_one_clk_wide", 32'(wide_cnt), 32'h0);
        check("done_ferr_exclusive", 32'(both_cnt), 32'h0);
        check("rec_data_stable", 32'(unstable_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
